// File: rtl/uart_tx_frame_if.sv
// Valid/ready word handshake between a word source and the UART transmitter.
// Ports: data_valid (source has a word), data (payload), data_ready (sink can take it).
interface uart_tx_frame_if #(
    parameter int DATA_BITS = 8
);
    logic                 data_valid;
    logic [DATA_BITS-1:0] data;
    logic                 data_ready;

    modport master (
        output data_valid,
        output data,
        input  data_ready
    );

    modport slave (
        input  data_valid,
        input  data,
        output data_ready
    );
endinterface

// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter with a one-entry holding register, so
// back-to-back words leave the pin with no idle gap between frames.
// Ports: clk, rst_n (async, active low), src (word handshake, slave side),
//        tx (serial line, idle high), tx_done (1-cycle end-of-frame pulse),
//        busy (frame on the line or word waiting).
module uart_tx_frame #(
    parameter int CLOCK_SPEED = 50_000_000,
    parameter int BAUD_RATE   = 115_200,
    parameter int BAUD_WIDTH  = CLOCK_SPEED / BAUD_RATE,
    parameter int DATA_BITS   = 8,
    parameter int PARITY      = 0,
    parameter int STOP_BITS   = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    uart_tx_frame_if.slave  src,
    output logic            tx,
    output logic            tx_done,
    output logic            busy
);

    generate
        if (BAUD_WIDTH < 2) begin : g_bad_baud
            $error("uart_tx_frame: BAUD_WIDTH must be at least 2");
        end
        if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
            $error("uart_tx_frame: DATA_BITS must be 5..9");
        end
        if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
            $error("uart_tx_frame: PARITY must be 0, 1 or 2");
        end
        if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
            $error("uart_tx_frame: STOP_BITS must be 1 or 2");
        end
    endgenerate

    localparam int CNT_W = (BAUD_WIDTH > 2) ? $clog2(BAUD_WIDTH) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(BAUD_WIDTH - 1);
    localparam logic [3:0]       DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic             STOP_LAST = 1'(STOP_BITS - 1);
    localparam logic             PAR_ODD   = (PARITY == 1);
    localparam logic             HAS_PAR   = (PARITY != 0);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_PAR   = 3'd3;
    localparam logic [2:0] S_STOP  = 3'd4;

    logic [2:0]           state;
    logic [CNT_W-1:0]     cnt;
    logic [3:0]           bit_idx;
    logic                 stop_idx;
    logic                 pending;
    logic [DATA_BITS-1:0] hold_reg;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 par_bit;

    logic bit_end;
    logic last_data;
    logic last_stop;
    logic accept;
    logic load;
    logic frame_end;

    assign bit_end   = (cnt == CNT_LAST);
    assign last_data = (bit_idx == DATA_LAST);
    assign last_stop = (stop_idx == STOP_LAST);
    assign frame_end = (state == S_STOP) && bit_end && last_stop;

    // accept needs an empty holding register, load needs a full one,
    // so the two can never happen on the same edge
    assign accept = src.data_valid && !pending;
    assign load   = pending && ((state == S_IDLE) || frame_end);

    assign src.data_ready = ~pending;
    assign busy           = (state != S_IDLE) || pending;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            stop_idx  <= 1'b0;
            pending   <= 1'b0;
            hold_reg  <= '0;
            shift_reg <= '0;
            par_bit   <= 1'b0;
            tx        <= 1'b1;
            tx_done   <= 1'b0;
        end else begin
            tx_done <= 1'b0;

            if (accept) begin
                pending  <= 1'b1;
                hold_reg <= src.data;
            end

            if (state != S_IDLE) begin
                cnt <= bit_end ? '0 : cnt + CNT_W'(1);
            end

            case (state)
                S_IDLE: begin
                    tx <= 1'b1;
                end
                S_START: begin
                    if (bit_end) begin
                        state   <= S_DATA;
                        bit_idx <= '0;
                        tx      <= shift_reg[0];
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        shift_reg <= shift_reg >> 1;
                        if (last_data) begin
                            if (HAS_PAR) begin
                                state <= S_PAR;
                                tx    <= par_bit;
                            end else begin
                                state    <= S_STOP;
                                stop_idx <= 1'b0;
                                tx       <= 1'b1;
                            end
                        end else begin
                            bit_idx <= bit_idx + 4'd1;
                            tx      <= shift_reg[1];
                        end
                    end
                end
                S_PAR: begin
                    if (bit_end) begin
                        state    <= S_STOP;
                        stop_idx <= 1'b0;
                        tx       <= 1'b1;
                    end
                end
                S_STOP: begin
                    if (bit_end) begin
                        if (last_stop) begin
                            tx_done <= 1'b1;
                            state   <= S_IDLE;
                        end else begin
                            stop_idx <= stop_idx + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                    tx    <= 1'b1;
                end
            endcase

            // start the next frame; in STOP this overrides the return to
            // IDLE so the new start bit follows the stop bit directly
            if (load) begin
                shift_reg <= hold_reg;
                par_bit   <= (^hold_reg) ^ PAR_ODD;
                pending   <= 1'b0;
                state     <= S_START;
                tx        <= 1'b0;
            end
        end
    end

endmodule
